// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths and the fetch FSM state encoding.
package cpu_pkg;

    localparam int unsigned PC_W    = 4;
    localparam int unsigned INSTR_W = 8;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StWait   = 2'd1,
        StValid  = 2'd2,
        StHalted = 2'd3
    } fetchState_t;

endpackage

// File: rtl/pc_reg.sv
// Program counter register: load has priority over increment, increment wraps at 2**PC_W.
module pc_reg
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [PC_W-1:0] loadVal,
    input  logic            inc,
    output logic [PC_W-1:0] pc
);

    logic [PC_W-1:0] pcQ;

    always_ff @(posedge clk) begin
        if (reset) begin
            pcQ <= '0;
        end else if (load) begin
            pcQ <= loadVal;
        end else if (inc) begin
            pcQ <= pcQ + PC_W'(1);
        end
    end

    assign pc = pcQ;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch FSM with branch squash and deferred halt.
// Optional 1-entry prefetch buffer enabled by defining IF_PREFETCH_EN.
module instr_fetch
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               fetch_req,
    input  logic               branch_en,
    input  logic [PC_W-1:0]    branch_target,
    input  logic               halt,
    output logic [PC_W-1:0]    mem_addr,
    output logic               mem_rd,
    input  logic [INSTR_W-1:0] mem_data,
    input  logic               mem_ack,
    output logic [INSTR_W-1:0] instruction,
    output logic               instr_valid,
    input  logic               ir_ready,
    output logic [PC_W-1:0]    pc,
    output logic               halted
);

    fetchState_t        stateQ, stateD;
    logic [INSTR_W-1:0] instrQ, instrD;
    logic               squashQ, squashD;
    logic               haltPendQ, haltPendD;
    logic               pcLoad, pcInc;

`ifdef IF_PREFETCH_EN
    logic               pfPendQ, pfPendD;
    logic               pfValidQ, pfValidD;
    logic [INSTR_W-1:0] pfDataQ, pfDataD;
    logic               pfAck;

    assign pfAck = pfPendQ & mem_ack;
`endif

    pc_reg u_pc_reg (
        .clk     (clk),
        .reset   (reset),
        .load    (pcLoad),
        .loadVal (branch_target),
        .inc     (pcInc),
        .pc      (pc)
    );

    always_comb begin
        stateD    = stateQ;
        instrD    = instrQ;
        squashD   = squashQ;
        haltPendD = haltPendQ;
        pcLoad    = 1'b0;
        pcInc     = 1'b0;
`ifdef IF_PREFETCH_EN
        pfPendD   = pfPendQ;
        pfValidD  = pfValidQ;
        pfDataD   = pfDataQ;
`endif
        unique case (stateQ)
            StIdle: begin
                pcLoad = branch_en;
                if (halt || haltPendQ) begin
                    stateD    = StHalted;
                    haltPendD = 1'b0;
                end else if (!branch_en && fetch_req) begin
                    stateD = StWait;
                end
            end
            StWait: begin
                if (halt) haltPendD = 1'b1;
                if (branch_en) begin
                    pcLoad  = 1'b1;
                    squashD = 1'b1;
                end
                if (mem_ack) begin
                    squashD = 1'b0;
                    // A redirect in this very cycle also squashes the returning word.
                    if (!squashQ && !branch_en) begin
                        instrD = mem_data;
                        pcInc  = 1'b1;
                        stateD = StValid;
                    end else begin
                        stateD = StIdle;
                    end
                end
            end
            StValid: begin
                if (halt) haltPendD = 1'b1;
`ifdef IF_PREFETCH_EN
                if (branch_en) begin
                    pcLoad   = 1'b1;
                    pfValidD = 1'b0;
                    pfPendD  = 1'b0;
                    // An unfinished prefetch drains through WAIT with its data squashed.
                    if (pfPendQ && !mem_ack) begin
                        squashD = 1'b1;
                        stateD  = StWait;
                    end else begin
                        stateD = StIdle;
                    end
                end else if (ir_ready) begin
                    if (pfValidQ) begin
                        instrD   = pfDataQ;
                        pfValidD = 1'b0;
                    end else if (pfAck) begin
                        instrD  = mem_data;
                        pcInc   = 1'b1;
                        pfPendD = 1'b0;
                    end else if (pfPendQ) begin
                        pfPendD = 1'b0;
                        stateD  = StWait;
                    end else begin
                        stateD = StIdle;
                    end
                end else if (pfAck) begin
                    pfDataD  = mem_data;
                    pfValidD = 1'b1;
                    pfPendD  = 1'b0;
                    pcInc    = 1'b1;
                end else if (!pfValidQ && !pfPendQ && !halt && !haltPendQ) begin
                    pfPendD = 1'b1;
                end
`else
                if (branch_en) begin
                    pcLoad = 1'b1;
                    stateD = StIdle;
                end else if (ir_ready) begin
                    stateD = StIdle;
                end
`endif
            end
            StHalted: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ    <= StIdle;
            instrQ    <= '0;
            squashQ   <= 1'b0;
            haltPendQ <= 1'b0;
        end else begin
            stateQ    <= stateD;
            instrQ    <= instrD;
            squashQ   <= squashD;
            haltPendQ <= haltPendD;
        end
    end

`ifdef IF_PREFETCH_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            pfPendQ  <= 1'b0;
            pfValidQ <= 1'b0;
            pfDataQ  <= '0;
        end else begin
            pfPendQ  <= pfPendD;
            pfValidQ <= pfValidD;
            pfDataQ  <= pfDataD;
        end
    end

    assign mem_rd = (stateQ == StWait) | pfPendQ;
`else
    assign mem_rd = (stateQ == StWait);
`endif

    assign mem_addr    = mem_rd ? pc : '0;
    assign instruction = instrQ;
    assign instr_valid = (stateQ == StValid);
    assign halted      = (stateQ == StHalted);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch (default build, prefetch disabled).
module tb_instr_fetch;

    logic       clk = 1'b0;
    logic       reset, fetch_req, branch_en, halt, mem_rd, mem_ack;
    logic       instr_valid, ir_ready, halted;
    logic [3:0] branch_target, mem_addr, pc;
    logic [7:0] mem_data, instruction;

    int nCompared = 0;
    int nMismatched = 0;

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk           (clk),
        .reset         (reset),
        .fetch_req     (fetch_req),
        .branch_en     (branch_en),
        .branch_target (branch_target),
        .halt          (halt),
        .mem_addr      (mem_addr),
        .mem_rd        (mem_rd),
        .mem_data      (mem_data),
        .mem_ack       (mem_ack),
        .instruction   (instruction),
        .instr_valid   (instr_valid),
        .ir_ready      (ir_ready),
        .pc            (pc),
        .halted        (halted)
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; fetch_req = 1'b0; branch_en = 1'b0; branch_target = 4'd0;
        halt = 1'b0; mem_data = 8'h00; mem_ack = 1'b0; ir_ready = 1'b0;
        step(); step();
        reset = 1'b0;
        checkVal("rst_pc", 32'(pc), 32'd0);
        checkVal("rst_mem_rd", 32'(mem_rd), 32'd0);
        checkVal("rst_mem_addr", 32'(mem_addr), 32'd0);
        checkVal("rst_valid", 32'(instr_valid), 32'd0);
        checkVal("rst_halted", 32'(halted), 32'd0);
        checkVal("rst_instr", 32'(instruction), 32'h00);

        // Basic fetch, ack one cycle after mem_rd.
        fetch_req = 1'b1; step();
        fetch_req = 1'b0;
        checkVal("f1_mem_rd", 32'(mem_rd), 32'd1);
        checkVal("f1_addr", 32'(mem_addr), 32'd0);
        checkVal("f1_valid_c1", 32'(instr_valid), 32'd0);
        mem_ack = 1'b1; mem_data = 8'hA5; step();
        mem_ack = 1'b0;
        checkVal("f1_valid_c2", 32'(instr_valid), 32'd1);
        checkVal("f1_instr", 32'(instruction), 32'hA5);
        checkVal("f1_pc", 32'(pc), 32'd1);
        checkVal("f1_rd_off", 32'(mem_rd), 32'd0);

        // Stall in VALID: no read issued, word held; stray ack ignored.
        for (int i = 0; i < 5; i++) begin
            mem_ack = (i == 2); mem_data = 8'hFF;
            step();
            checkVal("stall_instr", 32'(instruction), 32'hA5);
            checkVal("stall_rd", 32'(mem_rd), 32'd0);
            checkVal("stall_valid", 32'(instr_valid), 32'd1);
        end
        mem_ack = 1'b0;
        checkVal("stall_pc", 32'(pc), 32'd1);
        ir_ready = 1'b1; step();
        ir_ready = 1'b0;
        checkVal("consume_valid", 32'(instr_valid), 32'd0);

        // Branch in IDLE to 15, then fetch wraps pc to 0.
        branch_en = 1'b1; branch_target = 4'd15; fetch_req = 1'b1; step();
        branch_en = 1'b0;
        checkVal("br_idle_pc", 32'(pc), 32'd15);
        checkVal("br_idle_rd", 32'(mem_rd), 32'd0);
        step();
        fetch_req = 1'b0;
        checkVal("wrap_addr", 32'(mem_addr), 32'd15);
        mem_ack = 1'b1; mem_data = 8'h5A; step();
        mem_ack = 1'b0;
        checkVal("wrap_pc", 32'(pc), 32'd0);
        checkVal("wrap_instr", 32'(instruction), 32'h5A);
        ir_ready = 1'b1; step();
        ir_ready = 1'b0;

        // Branch during WAIT: ack after 3 cycles, data squashed.
        fetch_req = 1'b1; step();
        fetch_req = 1'b0;
        branch_en = 1'b1; branch_target = 4'd7; step();
        branch_en = 1'b0;
        checkVal("sq_pc", 32'(pc), 32'd7);
        checkVal("sq_rd_held", 32'(mem_rd), 32'd1);
        step();
        checkVal("sq_valid_a", 32'(instr_valid), 32'd0);
        mem_ack = 1'b1; mem_data = 8'h3C; step();
        mem_ack = 1'b0;
        checkVal("sq_valid_b", 32'(instr_valid), 32'd0);
        checkVal("sq_pc_noinc", 32'(pc), 32'd7);
        checkVal("sq_instr", 32'(instruction), 32'h5A);
        checkVal("sq_rd_off", 32'(mem_rd), 32'd0);
        fetch_req = 1'b1; step();
        fetch_req = 1'b0;
        checkVal("sq_next_addr", 32'(mem_addr), 32'd7);
        mem_ack = 1'b1; mem_data = 8'h11; step();
        mem_ack = 1'b0;
        checkVal("sq_next_instr", 32'(instruction), 32'h11);
        checkVal("sq_next_pc", 32'(pc), 32'd8);

        // Branch in VALID without ir_ready drops the word.
        branch_en = 1'b1; branch_target = 4'd10; step();
        branch_en = 1'b0;
        checkVal("brv_valid", 32'(instr_valid), 32'd0);
        checkVal("brv_pc", 32'(pc), 32'd10);

        // Branch together with ir_ready in VALID.
        fetch_req = 1'b1; step();
        fetch_req = 1'b0;
        mem_ack = 1'b1; mem_data = 8'h42; step();
        mem_ack = 1'b0;
        checkVal("brc_instr", 32'(instruction), 32'h42);
        branch_en = 1'b1; ir_ready = 1'b1; branch_target = 4'd8; step();
        branch_en = 1'b0; ir_ready = 1'b0;
        checkVal("brc_valid", 32'(instr_valid), 32'd0);
        checkVal("brc_pc", 32'(pc), 32'd8);

        // Halt during WAIT: word still delivered and consumed, then HALTED.
        fetch_req = 1'b1; step();
        fetch_req = 1'b0;
        halt = 1'b1; step();
        halt = 1'b0;
        checkVal("h_not_yet", 32'(halted), 32'd0);
        mem_ack = 1'b1; mem_data = 8'hC3; step();
        mem_ack = 1'b0;
        checkVal("h_valid", 32'(instr_valid), 32'd1);
        checkVal("h_instr", 32'(instruction), 32'hC3);
        checkVal("h_pc", 32'(pc), 32'd9);
        ir_ready = 1'b1; step();
        ir_ready = 1'b0;
        checkVal("h_idle", 32'(halted), 32'd0);
        step();
        checkVal("h_halted", 32'(halted), 32'd1);
        fetch_req = 1'b1; branch_en = 1'b1; branch_target = 4'd3; step();
        step();
        fetch_req = 1'b0; branch_en = 1'b0;
        checkVal("h_no_rd", 32'(mem_rd), 32'd0);
        checkVal("h_no_valid", 32'(instr_valid), 32'd0);
        checkVal("h_pc_kept", 32'(pc), 32'd9);
        checkVal("h_stay", 32'(halted), 32'd1);

        // Reset mid-read, then a stale ack.
        reset = 1'b1; step();
        reset = 1'b0;
        checkVal("r_halted", 32'(halted), 32'd0);
        fetch_req = 1'b1; step();
        fetch_req = 1'b0;
        checkVal("r_rd", 32'(mem_rd), 32'd1);
        reset = 1'b1; step();
        reset = 1'b0;
        mem_ack = 1'b1; mem_data = 8'h77; step();
        mem_ack = 1'b0;
        checkVal("r_stale_valid", 32'(instr_valid), 32'd0);
        checkVal("r_stale_pc", 32'(pc), 32'd0);
        checkVal("r_stale_instr", 32'(instruction), 32'h00);
        checkVal("r_stale_rd", 32'(mem_rd), 32'd0);
        step();
        checkVal("r_stale_valid2", 32'(instr_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
